// File: rtl/jtframe_bank_arb_pkg.sv
// jtframe_bank_arb_pkg
// Shared types and constants for the read-only SDRAM bank arbiter.
//   state_t    : arbiter FSM states
//   DEF_AW     : default SDRAM word address width
//   DEF_DW     : default data width (matches sdram_dout)
//   idx_width  : bits needed to index n slots (never less than 1)
package jtframe_bank_arb_pkg;

  localparam int DEF_AW = 22;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_t;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/jtframe_bank_arb_if.sv
// jtframe_bank_arb_if
// Bundles the client-side ROM slots and the SDRAM bank port of one arbiter.
//   slot_cs/slot_addr       : per-slot requests, slot i address at [i*AW +: AW]
//   slot_ok/slot_dout       : per-slot valid flag and data, slot i data at [i*DW +: DW]
//   ba_addr/ba_rd           : request towards the SDRAM controller
//   ba_ack/ba_rdy/sdram_dout: controller handshake and shared read data
// Modports: slave is the arbiter's view, master is the view of whatever drives
// the clients and models the SDRAM controller.
interface jtframe_bank_arb_if
  import jtframe_bank_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
);

  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic [AW-1:0]       ba_addr;
  logic                ba_rd;
  logic                ba_ack;
  logic                ba_rdy;
  logic [DW-1:0]       sdram_dout;

  modport slave (
    input  slot_cs, slot_addr, ba_ack, ba_rdy, sdram_dout,
    output slot_ok, slot_dout, ba_addr, ba_rd
  );

  modport master (
    output slot_cs, slot_addr, ba_ack, ba_rdy, sdram_dout,
    input  slot_ok, slot_dout, ba_addr, ba_rd
  );

endinterface

// File: rtl/jtframe_bank_arb_rr.sv
// jtframe_bank_arb_rr
// Combinational round-robin picker: returns the first set bit of 'pending'
// searching upward from index 'rr' with wrap-around.
//   pending : per-slot request vector
//   rr      : slot with the highest priority this round
//   gnt     : chosen slot index (0 when nothing is pending)
//   any     : at least one slot is pending
module jtframe_bank_arb_rr
  import jtframe_bank_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int IW    = idx_width(SLOTS)
) (
  input  logic [SLOTS-1:0] pending,
  input  logic [IW-1:0]    rr,
  output logic [IW-1:0]    gnt,
  output logic             any
);

  // Walk the rotated order from the far end back to rr so the candidate
  // closest to rr is the last one written and therefore wins.
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    any = 1'b0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (pending[idx]) begin
        gnt = IW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_bank_arb.sv
// jtframe_bank_arb
// Shares one read-only SDRAM bank among SLOTS ROM clients with round-robin
// arbitration. Each slot keeps one tagged data entry, so a client holding a
// stable address sees a persistent slot_ok without further SDRAM traffic.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : jtframe_bank_arb_if.slave (client slots + bank port)
// Optional macro JTFRAME_BANK_ARB_CACHE_EN: when defined, a slot entry
// survives slot_cs going low, so re-requesting the same address hits at once.
module jtframe_bank_arb
  import jtframe_bank_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  jtframe_bank_arb_if.slave  bus
);

  localparam int IW = idx_width(SLOTS);

  state_t              state_q, state_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [AW-1:0]       ba_addr_q, ba_addr_d;
  logic                ba_rd_q, ba_rd_d;
  logic [AW-1:0]       tag_q [SLOTS];
  logic [AW-1:0]       tag_d [SLOTS];
  logic [DW-1:0]       data_q [SLOTS];
  logic [DW-1:0]       data_d [SLOTS];
  logic [SLOTS-1:0]    valid_q, valid_d;

  logic [AW-1:0]       addr_w [SLOTS];
  logic [SLOTS-1:0]    ok_w;
  logic [SLOTS-1:0]    pending_w;
  logic [SLOTS*DW-1:0] dout_w;
  logic [IW-1:0]       pick;
  logic                pick_any;
  logic                done;

  // ok is purely combinational from the entry registers so it drops in the
  // very cycle a client moves to a different address.
  always_comb begin
    addr_w = '{default: '0};
    ok_w   = '0;
    dout_w = '0;
    for (int i = 0; i < SLOTS; i++) begin
      addr_w[i]           = bus.slot_addr[i*AW +: AW];
      ok_w[i]             = bus.slot_cs[i] & valid_q[i] & (addr_w[i] == tag_q[i]);
      dout_w[i*DW +: DW]  = data_q[i];
    end
    pending_w = bus.slot_cs & ~ok_w;
  end

  jtframe_bank_arb_rr #(
    .SLOTS (SLOTS),
    .IW    (IW)
  ) u_rr (
    .pending (pending_w),
    .rr      (rr_q),
    .gnt     (pick),
    .any     (pick_any)
  );

  // A fetch completes on ba_rdy in WAIT_RDY, or when ack and rdy coincide.
  // ba_rdy seen in IDLE belongs to nothing and is dropped.
  assign done = bus.ba_rdy & ((state_q == WAIT_RDY) | ((state_q == WAIT_ACK) & bus.ba_ack));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    ba_addr_d = ba_addr_q;
    ba_rd_d   = ba_rd_q;
    tag_d     = tag_q;
    data_d    = data_q;
    valid_d   = valid_q;
`ifndef JTFRAME_BANK_ARB_CACHE_EN
    valid_d   = valid_q & bus.slot_cs;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d     = pick;
          ba_addr_d = addr_w[pick];
          ba_rd_d   = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.ba_ack) begin
          ba_rd_d = 1'b0;
          state_d = bus.ba_rdy ? IDLE : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.ba_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The fetch cannot be cancelled, so the data is always stored under the
    // address actually fetched; a client that moved on simply misses the tag.
    // Completion is applied last so it beats the cs-low clear.
    if (done) begin
      data_d[gnt_q]  = bus.sdram_dout;
      tag_d[gnt_q]   = ba_addr_q;
      valid_d[gnt_q] = 1'b1;
      rr_d           = (gnt_q == IW'(SLOTS - 1)) ? '0 : gnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      ba_addr_q <= '0;
      ba_rd_q   <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      ba_addr_q <= ba_addr_d;
      ba_rd_q   <= ba_rd_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
    end
  end

  assign bus.slot_ok   = ok_w;
  assign bus.slot_dout = dout_w;
  assign bus.ba_addr   = ba_addr_q;
  assign bus.ba_rd     = ba_rd_q;

endmodule
